partial_full_adder1b: RTL and testbench

PARTIAL_FULL_ADDER1B -- requirements
Module: partial_full_adder1b

---
 rtl/partial_full_adder1b.sv | 68 ++++++
 tb/tb_partial_full_adder1b.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/partial_full_adder1b.sv
// One-bit sum/propagate/generate cell for carry-lookahead adders.
// The combinational outputs have an optional registered copy with a valid flag.
module partial_full_adder1b (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c_i,
    input  logic en,
    output logic s,
    output logic p,
    output logic g,
    output logic s_q,
    output logic p_q,
    output logic g_q,
    output logic vld_q
);

    logic s_d;
    logic p_d;
    logic g_d;
    logic vld_d;

    logic s_r;
    logic p_r;
    logic g_r;
    logic vld_r;

    // Propagate uses the OR form, so p and g never depend on c_i.
    always_comb begin
        s = a ^ b ^ c_i;
        p = a | b;
        g = a & b;
    end

    always_comb begin
        s_d   = s_r;
        p_d   = p_r;
        g_d   = g_r;
        vld_d = vld_r;
        if (en) begin
            s_d   = s;
            p_d   = p;
            g_d   = g;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r   <= 1'b0;
            p_r   <= 1'b0;
            g_r   <= 1'b0;
            vld_r <= 1'b0;
        end else begin
            s_r   <= s_d;
            p_r   <= p_d;
            g_r   <= g_d;
            vld_r <= vld_d;
        end
    end

    assign s_q   = s_r;
    assign p_q   = p_r;
    assign g_q   = g_r;
    assign vld_q = vld_r;

endmodule

// File: tb/tb_partial_full_adder1b.sv
// Directed bench for partial_full_adder1b: combinational sweep, capture/hold,
// reset behaviour and a 1000-cycle registered-output run with random carry-in.
module tb_partial_full_adder1b;

    logic clk;
    logic clk_run;
    logic rst_n;
    logic a;
    logic b;
    logic c_i;
    logic en;
    logic s;
    logic p;
    logic g;
    logic s_q;
    logic p_q;
    logic g_q;
    logic vld_q;

    int unsigned total;
    int unsigned bad;

    // Hand-computed {s,p,g} indexed by {a,b,c_i}.
    logic [2:0] spg_tbl [8];

    partial_full_adder1b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c_i   (c_i),
        .en    (en),
        .s     (s),
        .p     (p),
        .g     (g),
        .s_q   (s_q),
        .p_q   (p_q),
        .g_q   (g_q),
        .vld_q (vld_q)
    );

    initial clk = 1'b0;
    always #5 clk = clk_run ? ~clk : clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] spg_ref(input logic ra, input logic rb, input logic rc);
        return {ra ^ rb ^ rc, ra | rb, ra & rb};
    endfunction

    initial begin
        logic [2:0] idx;
        logic [2:0] exp_spg;

        total = 0;
        bad   = 0;
        spg_tbl[0] = 3'b000;
        spg_tbl[1] = 3'b100;
        spg_tbl[2] = 3'b110;
        spg_tbl[3] = 3'b010;
        spg_tbl[4] = 3'b110;
        spg_tbl[5] = 3'b010;
        spg_tbl[6] = 3'b011;
        spg_tbl[7] = 3'b111;

        // Clock stopped, reset held: combinational sweep, registers stay clear.
        clk_run = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b0;
        a       = 1'b0;
        b       = 1'b0;
        c_i     = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {a, b, c_i} = idx;
            #10;
            check_val($sformatf("comb_sweep_%0d", i), {1'b0, s, p, g}, {1'b0, spg_tbl[i]});
            check_val($sformatf("rst_regs_%0d", i), {s_q, p_q, g_q, vld_q}, 4'b0000);
        end

        // Clock running, reset held with en=1: nothing may be captured.
        clk_run = 1'b1;
        en = 1'b1;
        {a, b, c_i} = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("rst_no_capture_%0d", i), {s_q, p_q, g_q, vld_q}, 4'b0000);
        end

        // Release reset; first edge captures a=1,b=0,c_i=1.
        @(negedge clk);
        rst_n = 1'b1;
        {a, b, c_i} = 3'b101;
        #1;
        check_val("post_release_pre_edge", {s_q, p_q, g_q, vld_q}, 4'b0000);
        @(posedge clk);
        #1;
        check_val("capture_101", {s_q, p_q, g_q, vld_q}, 4'b0101);

        // en=0 holds across edges while combinational outputs follow inputs.
        @(negedge clk);
        en = 1'b0;
        {a, b, c_i} = 3'b000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("hold_%0d", i), {s_q, p_q, g_q, vld_q}, 4'b0101);
        end
        check_val("comb_after_hold", {1'b0, s, p, g}, 4'b0000);

        // Inputs changing right after the capturing edge must not leak in.
        @(negedge clk);
        en = 1'b1;
        {a, b, c_i} = 3'b110;
        @(posedge clk);
        #1;
        {a, b, c_i} = 3'b001;
        #1;
        check_val("capture_edge_value", {s_q, p_q, g_q, vld_q}, 4'b0111);
        check_val("comb_after_change", {1'b0, s, p, g}, 4'b0100);

        // Asynchronous reset between edges clears registers at once.
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_clear", {s_q, p_q, g_q, vld_q}, 4'b0000);
        check_val("rst_no_comb_effect", {1'b0, s, p, g}, 4'b0100);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        // 1000 captures with random carry-in; reference from the inputs driven before each edge.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a = i[0];
            b = i[1];
            c_i = 1'($urandom_range(0, 1));
            exp_spg = spg_ref(a, b, c_i);
            @(posedge clk);
            #1;
            check_val($sformatf("run_%0d", i), {s_q, p_q, g_q, vld_q}, {exp_spg, 1'b1});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
